sapho_io_bridge: RTL
====================

SAPHO_IO_BRIDGE -- requirements
Module: sapho_io_bridge

Interface
REQ-001 SHALL have parameter NUBITS, default 32, data word width.
REQ-002 SHALL have parameter NUIOIN, default 8, number of input ports (power of 2, >=2).
REQ-003 SHALL have parameter NUIOOU, default 8, number of output port addresses (power of 2, >=2).
REQ-004 SHALL have parameter ODEPTH, default 4, output FIFO depth in entries (power of 2, >=2).
REQ-005 SHALL have parameter ITRMSK, default 0, NUIOIN-bit mask of input ports that raise an interrupt.
REQ-006 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst  in  1  asynchronous, active-low reset (asserted when 0).
REQ-008 SHALL have port req_in  in  1  core input request (consume strobe).
REQ-009 SHALL have port addr_in  in  clog2(NUIOIN)  core input port select.
REQ-010 SHALL have port io_in  out  NUBITS  data returned to core.
REQ-011 SHALL have port out_en  in  1  core output write strobe.
REQ-012 SHALL have port addr_out  in  clog2(NUIOOU)  core output port address.
REQ-013 SHALL have port data_out  in  NUBITS  core output data.
REQ-014 SHALL have port itr  out  1  interrupt pulse to core.
REQ-015 SHALL have ports ext_in_data  in  NUIOIN*NUBITS, ext_in_valid  in  NUIOIN, ext_in_ready  out  NUIOIN; port i uses slice i.
REQ-016 SHALL have ports ext_out_valid  out  1, ext_out_ready  in  1, ext_out_addr  out  clog2(NUIOOU), ext_out_data  out  NUBITS.
REQ-017 SHALL have ports err_rd_empty  out  1 and err_ovf  out  1, sticky error flags.

Function
REQ-018 Each input port i SHALL own a one-entry holding buffer buf[i] with flag full[i].
REQ-019 ext_in_ready[i] SHALL equal !full[i], combinationally.
REQ-020 Input transfer on port i SHALL occur when ext_in_valid[i] && ext_in_ready[i]; buf[i] loads the data and full[i] sets at that edge.
REQ-021 io_in SHALL equal buf[addr_in] combinationally (zero latency), whether or not full[addr_in] is set.
REQ-022 req_in SHALL clear full[addr_in] at the next edge; the word read is the value before that edge.
REQ-023 req_in to an empty port SHALL return buf's current (stale) value and set err_rd_empty.
REQ-024 Same-cycle req_in and ext transfer on an empty port SHALL return the old buf value, set err_rd_empty, and leave full set with the new data.
REQ-025 The output FIFO SHALL store {addr_out,data_out}, ODEPTH entries, with wrapping read/write pointers and an occupancy count of clog2(ODEPTH)+1 bits.
REQ-026 out_en SHALL push when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-027 out_en while full without a same-cycle pop SHALL drop the word, leave FIFO contents unchanged, and set err_ovf.
REQ-028 ext_out_valid SHALL equal !empty; ext_out_addr/ext_out_data SHALL present the head entry combinationally.
REQ-029 A pop SHALL occur when ext_out_valid && ext_out_ready; the head advances at that edge.
REQ-030 Simultaneous push and pop on an empty FIFO SHALL push only (no pop, valid was low).
REQ-031 Let pend = |(full & ITRMSK); itr SHALL be a registered one-cycle pulse asserted the cycle after pend rises 0->1.
REQ-032 itr SHALL NOT re-pulse while pend stays 1; a new pulse requires pend to fall and rise again.
REQ-033 Error flags SHALL be sticky, cleared only by reset.

Reset
REQ-034 rst=0 SHALL asynchronously clear all full[i], all buf[i], FIFO pointers and count, err_rd_empty, err_ovf, itr and the pend history register.
REQ-035 Output values during reset: ext_in_ready all 1, ext_out_valid 0, itr 0, io_in 0, errors 0.
REQ-036 Reset asserted mid-transfer SHALL discard buffered and FIFO data with no partial state retained.
REQ-037 On rst release, the first edge SHALL accept transfers normally.

Verification
REQ-038 Port 2 ext write 0x0000_00AB, then req_in with addr_in=2 -> io_in=0xAB that cycle, full[2] clears, ext_in_ready[2]=1 next cycle, err_rd_empty=0.
REQ-039 req_in with addr_in=5 while port 5 is empty after reset -> io_in=0, err_rd_empty=1 and stays 1.
REQ-040 ODEPTH=4, ext_out_ready=0, five out_en writes data 1..5 -> FIFO holds 1..4, err_ovf=1; then drain -> heads 1,2,3,4, then valid=0.
REQ-041 FIFO full with ext_out_ready=1 and out_en same cycle -> head pops, new word accepted, count stays 4, err_ovf=0.
REQ-042 ITRMSK=8'b0000_0001, port 0 written -> itr=1 for exactly one cycle; second write after req_in drained it -> a second pulse.
REQ-043 rst pulled low with 2 FIFO entries and port 3 full -> ext_out_valid=0 and ext_in_ready[3]=1 immediately, without waiting for clk.

Source files
------------

// File: rtl/sapho_io_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sapho_io_bridge: per-port input holding buffers, output FIFO, interrupt. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sapho_io_bridge #(
  parameter int                NUBITS = 32,
  parameter int                NUIOIN = 8,
  parameter int                NUIOOU = 8,
  parameter int                ODEPTH = 4,
  parameter logic [NUIOIN-1:0] ITRMSK = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_in,
  input  logic [$clog2(NUIOIN)-1:0]   addr_in,
  output logic [NUBITS-1:0]           io_in,
  input  logic                        out_en,
  input  logic [$clog2(NUIOOU)-1:0]   addr_out,
  input  logic [NUBITS-1:0]           data_out,
  output logic                        itr,
  input  logic [NUIOIN*NUBITS-1:0]    ext_in_data,
  input  logic [NUIOIN-1:0]           ext_in_valid,
  output logic [NUIOIN-1:0]           ext_in_ready,
  output logic                        ext_out_valid,
  input  logic                        ext_out_ready,
  output logic [$clog2(NUIOOU)-1:0]   ext_out_addr,
  output logic [NUBITS-1:0]           ext_out_data,
  output logic                        err_rd_empty,
  output logic                        err_ovf
);

  localparam int AIW = $clog2(NUIOIN);
  localparam int AOW = $clog2(NUIOOU);
  localparam int PW  = $clog2(ODEPTH);
  localparam int CW  = PW + 1;
  localparam int EW  = AOW + NUBITS;
  localparam logic [CW-1:0] c_depth = CW'(ODEPTH);

  // ---------------- input side ----------------
  logic [NUBITS-1:0] r_buf [NUIOIN];
  logic [NUIOIN-1:0] r_full;
  logic [NUIOIN-1:0] w_in_xfer;
  logic [NUIOIN-1:0] w_rd_hit;
  logic              r_err_rd;

  assign ext_in_ready = ~r_full;
  assign w_in_xfer    = ext_in_valid & ~r_full;
  assign io_in        = r_buf[addr_in];

  always_comb begin
    w_rd_hit = '0;
    if (req_in)
      w_rd_hit[addr_in] = 1'b1;
  end

  // An arriving word wins over a same-cycle read: that read saw the old value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUIOIN; i++)
        r_buf[i] <= '0;
      r_full   <= '0;
      r_err_rd <= 1'b0;
    end else begin
      for (int i = 0; i < NUIOIN; i++) begin
        if (w_in_xfer[i]) begin
          r_buf[i]  <= ext_in_data[i*NUBITS +: NUBITS];
          r_full[i] <= 1'b1;
        end else if (w_rd_hit[i]) begin
          r_full[i] <= 1'b0;
        end
      end
      if (req_in && !r_full[addr_in])
        r_err_rd <= 1'b1;
    end
  end

  assign err_rd_empty = r_err_rd;

  // ---------------- output FIFO ----------------
  logic [EW-1:0] r_mem [ODEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_err_ovf;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic [EW-1:0] w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_depth);
  assign w_pop   = !w_empty && ext_out_ready;
  assign w_push  = out_en && (!w_full || w_pop);
  assign w_head  = r_mem[r_rptr];

  assign ext_out_valid = !w_empty;
  assign ext_out_addr  = w_head[NUBITS +: AOW];
  assign ext_out_data  = w_head[NUBITS-1:0];
  assign err_ovf       = r_err_ovf;

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= {addr_out, data_out};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_err_ovf <= 1'b0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (out_en && !w_push)
        r_err_ovf <= 1'b1;
    end
  end

  // ---------------- interrupt ----------------
  logic w_pend;
  logic r_pend_d;
  logic r_itr;

  assign w_pend = |(r_full & ITRMSK);
  assign itr    = r_itr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend_d <= 1'b0;
      r_itr    <= 1'b0;
    end else begin
      r_pend_d <= w_pend;
      r_itr    <= w_pend && !r_pend_d;
    end
  end

endmodule
`default_nettype wire
